// File: rtl/lock_reg_arbiter_if.sv
// Bus bundle for the lock-protected register: host and debug write ports,
// lock controls, responses and status.
interface lock_reg_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             Lock;
    logic             debug_unlocked;
    logic             host_req;
    logic [WIDTH-1:0] host_data;
    logic             dbg_req;
    logic [WIDTH-1:0] dbg_data;
    logic             host_ack;
    logic             host_nack;
    logic             dbg_ack;
    logic             dbg_nack;
    logic [WIDTH-1:0] Data_out;
    logic             lock_status;
    logic             dbg_window;
    logic [7:0]       reject_cnt;

    modport master (
        output Lock, debug_unlocked, host_req, host_data, dbg_req, dbg_data,
        input  host_ack, host_nack, dbg_ack, dbg_nack, Data_out,
               lock_status, dbg_window, reject_cnt
    );

    modport slave (
        input  Lock, debug_unlocked, host_req, host_data, dbg_req, dbg_data,
        output host_ack, host_nack, dbg_ack, dbg_nack, Data_out,
               lock_status, dbg_window, reject_cnt
    );
endinterface

// File: rtl/lock_reg_arbiter.sv
// Protected data register shared by host and debug writers; once locked only
// a time-limited debug window can write it, everything else is nacked.
module lock_reg_arbiter #(
    parameter int WIDTH      = 16,
    parameter int WIN_CYCLES = 8
) (
    input logic              Clk,
    input logic              resetn,
    lock_reg_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        DBG_WIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [7:0]       r_timer;
    logic [7:0]       w_timerNext;
    logic             r_rrDbg;
    logic             w_rrNext;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_dataNext;
    logic             r_hostAck;
    logic             r_hostNack;
    logic             r_dbgAck;
    logic             r_dbgNack;
    logic             w_hostAck;
    logic             w_hostNack;
    logic             w_dbgAck;
    logic             w_dbgNack;
    logic [7:0]       r_rejCnt;
    logic [7:0]       w_rejNext;
    logic [8:0]       w_nackSum;
    logic             w_hostElig;
    logic             w_dbgElig;

    // A requester still showing last cycle's response is not sampled again.
    assign w_hostElig = bus.host_req & ~r_hostAck & ~r_hostNack;
    assign w_dbgElig  = bus.dbg_req & ~r_dbgAck & ~r_dbgNack;

    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        w_hostAck   = 1'b0;
        w_hostNack  = 1'b0;
        w_dbgAck    = 1'b0;
        w_dbgNack   = 1'b0;
        case (r_state)
            UNLOCKED: begin
                if (w_hostElig && w_dbgElig) begin
                    w_hostAck = ~r_rrDbg;
                    w_dbgAck  = r_rrDbg;
                end else begin
                    w_hostAck = w_hostElig;
                    w_dbgAck  = w_dbgElig;
                end
                if (bus.Lock) w_stateNext = LOCKED;
            end
            LOCKED: begin
                w_hostNack = w_hostElig;
                w_dbgNack  = w_dbgElig;
                if (bus.debug_unlocked) begin
                    w_stateNext = DBG_WIN;
                    w_timerNext = 8'(WIN_CYCLES);
                end
            end
            DBG_WIN: begin
                w_hostNack  = w_hostElig;
                w_dbgAck    = w_dbgElig;
                w_timerNext = r_timer - 8'd1;
                // A timer of 1 here means this edge is the last window cycle.
                if (w_dbgElig || (r_timer == 8'd1) || !bus.debug_unlocked)
                    w_stateNext = LOCKED;
            end
            default: w_stateNext = UNLOCKED;
        endcase
    end

    always_comb begin
        w_dataNext = r_data;
        w_rrNext   = r_rrDbg;
        if (w_hostAck) w_dataNext = bus.host_data;
        else if (w_dbgAck) w_dataNext = bus.dbg_data;
        if (w_hostAck || w_dbgAck) w_rrNext = ~r_rrDbg;
        w_nackSum = {1'b0, r_rejCnt} + {8'd0, w_hostNack} + {8'd0, w_dbgNack};
        w_rejNext = (w_nackSum > 9'd255) ? 8'hFF : w_nackSum[7:0];
    end

    always_ff @(posedge Clk) begin
        if (!resetn) begin
            r_state    <= UNLOCKED;
            r_timer    <= 8'd0;
            r_rrDbg    <= 1'b0;
            r_data     <= '0;
            r_hostAck  <= 1'b0;
            r_hostNack <= 1'b0;
            r_dbgAck   <= 1'b0;
            r_dbgNack  <= 1'b0;
            r_rejCnt   <= 8'd0;
        end else begin
            r_state    <= w_stateNext;
            r_timer    <= w_timerNext;
            r_rrDbg    <= w_rrNext;
            r_data     <= w_dataNext;
            r_hostAck  <= w_hostAck;
            r_hostNack <= w_hostNack;
            r_dbgAck   <= w_dbgAck;
            r_dbgNack  <= w_dbgNack;
            r_rejCnt   <= w_rejNext;
        end
    end

    assign bus.host_ack    = r_hostAck;
    assign bus.host_nack   = r_hostNack;
    assign bus.dbg_ack     = r_dbgAck;
    assign bus.dbg_nack    = r_dbgNack;
    assign bus.Data_out    = r_data;
    assign bus.reject_cnt  = r_rejCnt;
    assign bus.lock_status = (r_state != UNLOCKED);
    assign bus.dbg_window  = (r_state == DBG_WIN);

endmodule

// File: tb/tb_lock_reg_arbiter.sv
// Self-checking bench for lock_reg_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_lock_reg_arbiter;

    localparam int WIDTH = 16;
    localparam int WIN   = 8;

    logic Clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    lock_reg_arbiter_if #(.WIDTH(WIDTH)) bus ();

    lock_reg_arbiter #(.WIDTH(WIDTH), .WIN_CYCLES(WIN)) dut (
        .Clk    (Clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        rstn;
        logic        lock;
        logic        unl;
        logic        hReq;
        logic [15:0] hData;
        logic        dReq;
        logic [15:0] dData;
        logic        hAck;
        logic        hNack;
        logic        dAck;
        logic        dNack;
        logic [15:0] data;
        logic [7:0]  rej;
        logic        lockSt;
        logic        win;
    } vec_t;

    // Behavioural model: a locked flag, remaining window cycles, and who still
    // shows a response; expectations for the next edge are derived from these.
    bit          mLocked;
    int          mWinLeft;
    bit          mFavorHost;
    bit          mHostBusy, mDbgBusy;
    bit          mHAck, mHNack, mDAck, mDNack;
    logic [15:0] mData;
    int          mRej;

    task automatic modelEdge();
        bit hE, dE;
        bit hA, hN, dA, dN;
        if (!resetn) begin
            mLocked = 0; mWinLeft = 0; mFavorHost = 1; mData = '0; mRej = 0;
            mHAck = 0; mHNack = 0; mDAck = 0; mDNack = 0;
        end else begin
            hE = bus.host_req && !mHostBusy;
            dE = bus.dbg_req && !mDbgBusy;
            hA = 0; hN = 0; dA = 0; dN = 0;
            if (!mLocked) begin
                if (hE && dE) begin
                    hA = mFavorHost;
                    dA = !mFavorHost;
                end else begin
                    hA = hE;
                    dA = dE;
                end
                if (bus.Lock) mLocked = 1;
            end else if (mWinLeft > 0) begin
                hN = hE;
                dA = dE;
                mWinLeft = mWinLeft - 1;
                if (dA || !bus.debug_unlocked) mWinLeft = 0;
            end else begin
                hN = hE;
                dN = dE;
                if (bus.debug_unlocked) mWinLeft = WIN;
            end
            if (hA) mData = bus.host_data;
            else if (dA) mData = bus.dbg_data;
            if (hA || dA) mFavorHost = !mFavorHost;
            mRej = mRej + int'(hN) + int'(dN);
            if (mRej > 255) mRej = 255;
            mHAck = hA; mHNack = hN; mDAck = dA; mDNack = dN;
        end
        mHostBusy = mHAck || mHNack;
        mDbgBusy  = mDAck || mDNack;
    endtask

    task automatic applyStimulus(input logic rstn, input logic lock, input logic unl,
                                 input logic hReq, input logic [15:0] hData,
                                 input logic dReq, input logic [15:0] dData);
        resetn             = rstn;
        bus.Lock           = lock;
        bus.debug_unlocked = unl;
        bus.host_req       = hReq;
        bus.host_data      = hData;
        bus.dbg_req        = dReq;
        bus.dbg_data       = dData;
        modelEdge();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic hAck, input logic hNack,
                               input logic dAck, input logic dNack, input logic [15:0] data,
                               input logic [7:0] rej, input logic lockSt, input logic win);
        chk({tag, ".host_ack"},    32'(bus.host_ack),    32'(hAck));
        chk({tag, ".host_nack"},   32'(bus.host_nack),   32'(hNack));
        chk({tag, ".dbg_ack"},     32'(bus.dbg_ack),     32'(dAck));
        chk({tag, ".dbg_nack"},    32'(bus.dbg_nack),    32'(dNack));
        chk({tag, ".Data_out"},    32'(bus.Data_out),    32'(data));
        chk({tag, ".reject_cnt"},  32'(bus.reject_cnt),  32'(rej));
        chk({tag, ".lock_status"}, 32'(bus.lock_status), 32'(lockSt));
        chk({tag, ".dbg_window"},  32'(bus.dbg_window),  32'(win));
    endtask

    initial begin
        vec_t vecs[$];

        bus.Lock = 0; bus.debug_unlocked = 0; bus.host_req = 0; bus.host_data = '0;
        bus.dbg_req = 0; bus.dbg_data = '0;
        mHostBusy = 0; mDbgBusy = 0;

        // rstn lock unl hReq hData dReq dData | hAck hNack dAck dNack data rej lock win
        vecs.push_back('{0,0,0,0,16'h0000,0,16'h0000, 0,0,0,0,16'h0000,8'd0,0,0});
        vecs.push_back('{1,0,0,1,16'hA5A5,0,16'h0000, 1,0,0,0,16'hA5A5,8'd0,0,0});
        vecs.push_back('{1,0,0,1,16'hA5A5,0,16'h0000, 0,0,0,0,16'hA5A5,8'd0,0,0});
        vecs.push_back('{0,0,0,0,16'h0000,0,16'h0000, 0,0,0,0,16'h0000,8'd0,0,0});
        vecs.push_back('{1,0,0,1,16'h1111,1,16'h2222, 1,0,0,0,16'h1111,8'd0,0,0});
        vecs.push_back('{1,0,0,1,16'h1111,1,16'h2222, 0,0,1,0,16'h2222,8'd0,0,0});
        vecs.push_back('{1,0,0,0,16'h0000,0,16'h0000, 0,0,0,0,16'h2222,8'd0,0,0});
        vecs.push_back('{1,1,0,0,16'h0000,0,16'h0000, 0,0,0,0,16'h2222,8'd0,1,0});
        vecs.push_back('{1,0,0,1,16'hBEEF,0,16'h0000, 0,1,0,0,16'h2222,8'd1,1,0});
        vecs.push_back('{1,0,0,0,16'h0000,0,16'h0000, 0,0,0,0,16'h2222,8'd1,1,0});
        vecs.push_back('{1,1,0,0,16'h0000,0,16'h0000, 0,0,0,0,16'h2222,8'd1,1,0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].lock, vecs[i].unl, vecs[i].hReq,
                          vecs[i].hData, vecs[i].dReq, vecs[i].dData);
            checkOutput($sformatf("vec%0d", i), vecs[i].hAck, vecs[i].hNack, vecs[i].dAck,
                        vecs[i].dNack, vecs[i].data, vecs[i].rej, vecs[i].lockSt, vecs[i].win);
        end

        // Debug window opens, one dbg write lands and closes it.
        applyStimulus(1, 0, 1, 0, 16'h0, 0, 16'h0);
        checkOutput("dbgOpen", 0, 0, 0, 0, 16'h2222, 8'd1, 1, 1);
        applyStimulus(1, 0, 1, 0, 16'h0, 1, 16'h0F0F);
        checkOutput("dbgWrite", 0, 0, 1, 0, 16'h0F0F, 8'd1, 1, 0);
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 16'h0);
        checkOutput("dbgIdle", 0, 0, 0, 0, 16'h0F0F, 8'd1, 1, 0);
        applyStimulus(1, 0, 0, 0, 16'h0, 1, 16'h3333);
        checkOutput("dbgSecond", 0, 0, 0, 1, 16'h0F0F, 8'd2, 1, 0);
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 16'h0);

        // Window left to expire: stays open exactly WIN cycles.
        applyStimulus(1, 0, 1, 0, 16'h0, 0, 16'h0);
        checkOutput("winEnter", 0, 0, 0, 0, 16'h0F0F, 8'd2, 1, 1);
        for (int i = 1; i < WIN; i++) begin
            applyStimulus(1, 0, 1, 0, 16'h0, 0, 16'h0);
            chk($sformatf("winOpen%0d", i), 32'(bus.dbg_window), 32'd1);
        end
        applyStimulus(1, 0, 1, 0, 16'h0, 0, 16'h0);
        checkOutput("winExpired", 0, 0, 0, 0, 16'h0F0F, 8'd2, 1, 0);
        applyStimulus(1, 0, 0, 0, 16'h0, 1, 16'h4444);
        checkOutput("winLateReq", 0, 0, 0, 1, 16'h0F0F, 8'd3, 1, 0);
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 16'h0);

        // 300 locked host requests saturate the reject counter.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 0, 0, 1, 16'(i), 0, 16'h0);
            applyStimulus(1, 0, 0, 0, 16'h0, 0, 16'h0);
        end
        checkOutput("saturated", 0, 0, 0, 0, 16'h0F0F, 8'd255, 1, 0);
        applyStimulus(0, 0, 1, 1, 16'hFFFF, 1, 16'hFFFF);
        checkOutput("resetAfterSat", 0, 0, 0, 0, 16'h0000, 8'd0, 0, 0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(logic'($urandom_range(0, 199) != 0),
                          logic'($urandom_range(0, 24) == 0),
                          logic'($urandom_range(0, 3) != 0),
                          logic'($urandom_range(0, 1)), 16'($urandom),
                          logic'($urandom_range(0, 1)), 16'($urandom));
            checkOutput($sformatf("rnd%0d", i), mHAck, mHNack, mDAck, mDNack, mData,
                        8'(mRej), mLocked, (mWinLeft > 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_reg_arbiter.md
LOCK_REG_ARBITER -- requirements
Module: lock_reg_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the protected data register width.
REQ-002 The block SHALL have parameter WIN_CYCLES, default 8, giving the debug write window length in cycles (1..255).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port Lock, input, 1 bit: lock request, level or pulse.
REQ-006 The block SHALL have port debug_unlocked, input, 1 bit: debug authorisation from the debug TAP.
REQ-007 The block SHALL have ports host_req (input, 1 bit) and host_data (input, WIDTH): host write request and data.
REQ-008 The block SHALL have ports dbg_req (input, 1 bit) and dbg_data (input, WIDTH): debug write request and data.
REQ-009 The block SHALL have ports host_ack, host_nack, dbg_ack and dbg_nack, each output, 1 bit: single-cycle write accepted/rejected pulses.
REQ-010 The block SHALL have port Data_out, output, WIDTH bits: the protected register.
REQ-011 The block SHALL have ports lock_status and dbg_window, each output, 1 bit: status bits; high in LOCKED or DBG_WIN, and high in DBG_WIN only, respectively.
REQ-012 The block SHALL have port reject_cnt, output, 8 bits: saturating count of nacks.

Function
REQ-013 The FSM SHALL have exactly three states: UNLOCKED, LOCKED and DBG_WIN.
REQ-014 In UNLOCKED, Lock=1 SHALL move to LOCKED on the next edge; debug_unlocked SHALL be ignored.
REQ-015 LOCKED SHALL be left only via reset or entry to DBG_WIN; Lock SHALL have no further effect while LOCKED.
REQ-016 In LOCKED, debug_unlocked=1 SHALL move to DBG_WIN and load the window timer with WIN_CYCLES.
REQ-017 In DBG_WIN the timer SHALL decrement each cycle.
REQ-018 DBG_WIN SHALL return to LOCKED on the earliest of: the edge accepting a dbg write, timer reaching 0, or debug_unlocked=0.
REQ-019 A request SHALL be sampled at an edge and answered by exactly one ack or nack pulse, high for the following cycle only.
REQ-020 Data_out SHALL load the granted data on the same edge that raises that requester's ack.
REQ-021 A requester whose ack or nack is currently high SHALL NOT be sampled that cycle, so a held req yields one response.
REQ-022 In UNLOCKED both requesters SHALL be writable.
REQ-023 If both requesters are eligible together, a round-robin pointer SHALL decide; the winner is acked and the loser gets no response and is re-evaluated next cycle.
REQ-024 The round-robin pointer SHALL toggle after each ack; its reset value SHALL favour host.
REQ-025 In LOCKED, every sampled request SHALL be nacked; both requesters may be nacked in the same cycle.
REQ-026 In DBG_WIN, host requests SHALL be nacked, and a dbg request SHALL be acked and end the window.
REQ-027 If Lock and a write are sampled in the same UNLOCKED cycle, the write SHALL be acked using pre-lock state; LOCKED applies from the next edge.
REQ-028 A dbg request and window expiry on the same edge SHALL be acked, since the window is still open when sampled.
REQ-029 reject_cnt SHALL increment by the number of nacks issued at each edge (0, 1 or 2).
REQ-030 reject_cnt SHALL saturate at 255 and never wrap.
REQ-031 Data_out SHALL never change except on an ack edge.

Reset
REQ-032 With resetn=0 at an edge, the block SHALL enter UNLOCKED with pointer favouring host.
REQ-033 With resetn=0 at an edge, Data_out and reject_cnt SHALL clear to 0 and all ack/nack, lock_status and dbg_window outputs SHALL go low.
REQ-034 Reset SHALL override all inputs, including mid-window and mid-response; pending responses SHALL be discarded.

Verification
REQ-035 Bench SHALL cover: UNLOCKED, host_req=1, host_data=16'hA5A5 -> host_ack for 1 cycle, Data_out=16'hA5A5 the same cycle, no second ack while req is held.
REQ-036 Bench SHALL cover: UNLOCKED, host_req and dbg_req held together with data 16'h1111 and 16'h2222 -> host acked first (Data_out=16'h1111), dbg acked next cycle (Data_out=16'h2222).
REQ-037 Bench SHALL cover: Lock pulse, then host_req with 16'hBEEF -> host_nack, Data_out unchanged, reject_cnt=1, lock_status=1.
REQ-038 Bench SHALL cover: LOCKED, debug_unlocked=1, dbg_req with 16'h0F0F -> dbg_ack, Data_out=16'h0F0F, dbg_window low on the next cycle, and a second dbg_req is nacked.
REQ-039 Bench SHALL cover: DBG_WIN with WIN_CYCLES=8 and no requests -> window closes after 8 cycles, and a later dbg_req is nacked.
REQ-040 Bench SHALL cover: 300 locked host requests -> reject_cnt=255; then resetn=0 for one edge -> UNLOCKED, Data_out=0, reject_cnt=0.
